imem_responder: RTL and testbench

- Memory-side responder for the instruction-cache read interface.
- Accepts a level-held read request and returns one 32-bit word from an internal word-addressed array after a fixed, parameterised latency.
- Sits between the instruction cache's memory port and on-chip instruction RAM.
- Also provides a loader write port, so the boot path can fill program memory before or while the core runs.

---
 rtl/imem_responder_if.sv | 22 ++
 rtl/imem_responder.sv | 102 ++++++++++
 tb/tb_imem_responder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
// Instruction-memory read port (cache side) plus boot-loader write port for imem_responder.
interface imem_responder_if;
    logic        memory_read_request;
    logic [31:0] memory_addr;
    logic        memory_read_response;
    logic [31:0] memory_read_data;
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        busy;
    logic        addr_error;

    modport master (
        output memory_read_request, memory_addr, load_we, load_addr, load_data,
        input  memory_read_response, memory_read_data, busy, addr_error
    );

    modport slave (
        input  memory_read_request, memory_addr, load_we, load_addr, load_data,
        output memory_read_response, memory_read_data, busy, addr_error
    );
endinterface

// File: rtl/imem_responder.sv
// Fixed-latency instruction RAM responder: one word per level-held request, with an
// always-available loader write port. At most one transaction in flight.
module imem_responder #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter              MEMORY_FILE = "",
  parameter logic [31:0] OOR_DATA    = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  imem_responder_if.slave bus
);
  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  logic [31:0]   r_mem [MEM_WORDS];
  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_idx;
  logic          r_oor;
  logic [31:0]   r_data;

  logic [AW-1:0] w_req_idx;
  logic [AW-1:0] w_ld_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_req_oor;
  logic          w_ld_oor;
  logic          w_rd_oor;
  logic          w_accept;
  logic          w_capture;

  assign w_req_idx = bus.memory_addr[AW+1:2];
  assign w_req_oor = |(bus.memory_addr >> (AW + 2));
  assign w_ld_idx  = bus.load_addr[AW+1:2];
  assign w_ld_oor  = |(bus.load_addr >> (AW + 2));

  assign w_accept  = (r_state == S_IDLE) && bus.memory_read_request;
  assign w_capture = (w_next == S_RESP) && (r_state != S_RESP);
  // With LATENCY=1 the capture edge is the acceptance edge, so read the live address.
  assign w_rd_idx  = (r_state == S_IDLE) ? w_req_idx : r_idx;
  assign w_rd_oor  = (r_state == S_IDLE) ? w_req_oor : r_oor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The counter reaches zero on the edge that enters RESP.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.memory_read_request) w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt <= CW'(1)) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.memory_read_response = (r_state == S_RESP);
    bus.busy                 = (r_state != S_IDLE);
    bus.addr_error           = (r_state == S_RESP) && r_oor;
    bus.memory_read_data     = r_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_oor  <= 1'b0;
      r_data <= '0;
    end else begin
      if (w_accept) begin
        r_cnt <= CW'(LATENCY - 1);
        r_idx <= w_req_idx;
        r_oor <= w_req_oor;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_capture) begin
        r_data <= w_rd_oor ? OOR_DATA : r_mem[w_rd_idx];
      end
    end
  end

  // Same-edge loader write lands after the read sample: read-before-write.
  always_ff @(posedge clk) begin
    if (bus.load_we && !w_ld_oor) begin
      r_mem[w_ld_idx] <= bus.load_data;
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// Drives LATENCY=2/1/4 responders with one shared stimulus and checks them against
// a timestamp-based transaction model every cycle, plus literal spot checks.
module tb_imem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [31:0] laddr = '0;
    logic [31:0] ldata = '0;

    int errors = 0;
    int checks = 0;

    imem_responder_if bus_l2();
    imem_responder_if bus_l1();
    imem_responder_if bus_l4();

    assign bus_l2.memory_read_request = req;
    assign bus_l2.memory_addr         = addr;
    assign bus_l2.load_we             = we;
    assign bus_l2.load_addr           = laddr;
    assign bus_l2.load_data           = ldata;
    assign bus_l1.memory_read_request = req;
    assign bus_l1.memory_addr         = addr;
    assign bus_l1.load_we             = we;
    assign bus_l1.load_addr           = laddr;
    assign bus_l1.load_data           = ldata;
    assign bus_l4.memory_read_request = req;
    assign bus_l4.memory_addr         = addr;
    assign bus_l4.load_we             = we;
    assign bus_l4.load_addr           = laddr;
    assign bus_l4.load_data           = ldata;

    imem_responder #(.LATENCY(2)) u_l2 (.clk(clk), .rst_n(rst_n), .bus(bus_l2));
    imem_responder #(.LATENCY(1)) u_l1 (.clk(clk), .rst_n(rst_n), .bus(bus_l1));
    imem_responder #(.LATENCY(4)) u_l4 (.clk(clk), .rst_n(rst_n), .bus(bus_l4));

    always #5 clk = ~clk;

    logic        resp_o [3];
    logic        busy_o [3];
    logic        err_o  [3];
    logic [31:0] data_o [3];

    assign resp_o[0] = bus_l2.memory_read_response;
    assign busy_o[0] = bus_l2.busy;
    assign err_o[0]  = bus_l2.addr_error;
    assign data_o[0] = bus_l2.memory_read_data;
    assign resp_o[1] = bus_l1.memory_read_response;
    assign busy_o[1] = bus_l1.busy;
    assign err_o[1]  = bus_l1.addr_error;
    assign data_o[1] = bus_l1.memory_read_data;
    assign resp_o[2] = bus_l4.memory_read_response;
    assign busy_o[2] = bus_l4.busy;
    assign err_o[2]  = bus_l4.addr_error;
    assign data_o[2] = bus_l4.memory_read_data;

    int lat [3] = '{2, 1, 4};

    // Model: a transaction accepted at edge number acc responds after edge acc+lat-1.
    logic [31:0] mm [1024];
    int          n;
    bit          act      [3];
    int          acc      [3];
    int          redge    [3];
    int          nok      [3];
    logic [31:0] la       [3];
    logic [31:0] exp_data [3];
    bit          exp_err  [3];

    function automatic bit is_oor(input logic [31:0] a);
        return a >= 32'd4096;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a / 32'd4) % 32'd1024);
    endfunction

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            act[k]      = 1'b0;
            nok[k]      = 0;
            exp_data[k] = '0;
            exp_err[k]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (req && n >= nok[k]) begin
                act[k]   = 1'b1;
                acc[k]   = n;
                redge[k] = n + lat[k] - 1;
                nok[k]   = redge[k] + 2;
                la[k]    = addr;
            end
            if (act[k] && n == redge[k]) begin
                exp_err[k]  = is_oor(la[k]);
                exp_data[k] = is_oor(la[k]) ? 32'h0000_0013 : mm[widx(la[k])];
            end
        end
        if (we && !is_oor(laddr)) mm[widx(laddr)] = ldata;
    endtask

    task automatic compare();
        bit eb, er;
        for (int k = 0; k < 3; k++) begin
            eb = act[k] && n >= acc[k] && n <= redge[k];
            er = act[k] && n == redge[k];
            chk($sformatf("L%0d busy", lat[k]), 32'(busy_o[k]), 32'(eb));
            chk($sformatf("L%0d resp", lat[k]), 32'(resp_o[k]), 32'(er));
            chk($sformatf("L%0d addr_error", lat[k]), 32'(err_o[k]), 32'(er && exp_err[k]));
            chk($sformatf("L%0d data", lat[k]), data_o[k], exp_data[k]);
        end
    endtask

    initial begin
        n = 0;
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else begin
                n++;
                model_edge();
            end
            @(negedge clk);
            if (!rst_n) model_reset();
            compare();
        end
    end

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; laddr = a; ldata = d;
        step(1);
        we = 1'b0;
    endtask

    initial begin
        step(2);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst L%0d resp", lat[k]), 32'(resp_o[k]), 32'd0);
            chk($sformatf("rst L%0d busy", lat[k]), 32'(busy_o[k]), 32'd0);
            chk($sformatf("rst L%0d data", lat[k]), data_o[k], 32'd0);
            chk($sformatf("rst L%0d err", lat[k]), 32'(err_o[k]), 32'd0);
        end
        #1 rst_n = 1'b1;

        load(32'h14, 32'hDEAD_BEEF);
        load(32'h1C, 32'hAAAA_AAAA);
        load(32'h0C, 32'h0BAD_F00D);
        load(32'h00, 32'h1111_1111);

        // Basic read, request held one cycle past the response.
        req = 1'b1; addr = 32'h14;
        step(1);
        chk("t1 L2 busy after accept", 32'(busy_o[0]), 32'd1);
        chk("t1 L2 resp early", 32'(resp_o[0]), 32'd0);
        step(1);
        chk("t1 L2 resp", 32'(resp_o[0]), 32'd1);
        chk("t1 L2 data", data_o[0], 32'hDEAD_BEEF);
        chk("t1 L2 err", 32'(err_o[0]), 32'd0);
        step(1);
        chk("t1 L2 resp single", 32'(resp_o[0]), 32'd0);
        chk("t1 L2 busy cleared", 32'(busy_o[0]), 32'd0);
        req = 1'b0;
        step(1);
        chk("t1 L2 no second txn", 32'(busy_o[0]), 32'd0);
        step(3);

        // Flush: request dropped right after acceptance.
        req = 1'b1; addr = 32'h0C;
        step(1);
        req = 1'b0; addr = 32'h1C;
        step(1);
        chk("flush L2 resp", 32'(resp_o[0]), 32'd1);
        chk("flush L2 data", data_o[0], 32'h0BAD_F00D);
        step(2);
        chk("flush L4 resp", 32'(resp_o[2]), 32'd1);
        chk("flush L4 data", data_o[2], 32'h0BAD_F00D);
        step(2);

        // Out-of-range read plus dropped out-of-range write aliasing word 0.
        req = 1'b1; addr = 32'h0001_0000;
        we = 1'b1; laddr = 32'h0001_0000; ldata = 32'hFFFF_FFFF;
        step(1);
        req = 1'b0; we = 1'b0;
        step(1);
        chk("oor L2 data", data_o[0], 32'h0000_0013);
        chk("oor L2 err", 32'(err_o[0]), 32'd1);
        step(1);
        chk("oor L2 err pulse", 32'(err_o[0]), 32'd0);
        step(3);
        req = 1'b1; addr = 32'h0;
        step(1);
        req = 1'b0;
        step(1);
        chk("oor write dropped", data_o[0], 32'h1111_1111);
        step(3);

        // Loader write to word 7 on the L2 capture edge.
        req = 1'b1; addr = 32'h1C;
        step(1);
        req = 1'b0;
        we = 1'b1; laddr = 32'h1C; ldata = 32'h1234_5678;
        step(1);
        we = 1'b0;
        chk("rbw L2 old data", data_o[0], 32'hAAAA_AAAA);
        step(4);
        req = 1'b1; addr = 32'h1C;
        step(1);
        req = 1'b0;
        step(1);
        chk("rbw L2 new data", data_o[0], 32'h1234_5678);
        step(3);

        // Reset mid-transaction.
        req = 1'b1; addr = 32'h14;
        step(1);
        req = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("midrst L%0d resp", lat[k]), 32'(resp_o[k]), 32'd0);
            chk($sformatf("midrst L%0d busy", lat[k]), 32'(busy_o[k]), 32'd0);
            chk($sformatf("midrst L%0d data", lat[k]), data_o[k], 32'd0);
        end
        step(2);
        #1 rst_n = 1'b1;
        step(4);
        req = 1'b1; addr = 32'h14;
        step(1);
        req = 1'b0;
        chk("post-rst L1 resp", 32'(resp_o[1]), 32'd1);
        chk("post-rst L1 data", data_o[1], 32'hDEAD_BEEF);
        step(3);
        chk("post-rst L4 resp", 32'(resp_o[2]), 32'd1);
        chk("post-rst L4 data", data_o[2], 32'hDEAD_BEEF);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
